hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage core. Tracks in-flight destination tags for EX/MEM/WB in a

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_tag_pipe.sv | 33 +++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: writeback sources,
// forwarding selects and the width of the per-stage tag control bits.
package hazard_pkg;

  typedef enum logic [1:0] {
    WD_ALU  = 2'b00,
    WD_DRAM = 2'b01,
    WD_IMM  = 2'b10,
    WD_PC4  = 2'b11
  } wd_sel_e;

  typedef enum logic [2:0] {
    FWD_RF     = 3'b000,
    FWD_EX_RES = 3'b001,
    FWD_EX_IMM = 3'b010,
    FWD_MEM    = 3'b011,
    FWD_WB     = 3'b100
  } fwd_sel_e;

  // Tag = {valid, rd, we, wd_sel}; this counts every bit except rd.
  localparam int TAG_CTRL_W = 4;

  // Results that are not available in EX and cannot be forwarded from there.
  function automatic logic is_late_result(wd_sel_e wd);
    return (wd == WD_DRAM) || (wd == WD_PC4);
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shadow tag shift register mirroring the EX/MEM/WB stage registers.
// hold freezes all three stages; bubble inserts an invalid tag into EX.
module hazard_tag_pipe #(
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             bubble,
  input  logic [TAG_W-1:0] id_tag,
  output logic [TAG_W-1:0] ex_tag,
  output logic [TAG_W-1:0] mem_tag,
  output logic [TAG_W-1:0] wb_tag
);

  // The valid flag is the MSB of the tag.
  localparam logic [TAG_W-1:0] VALID_MASK = {1'b1, {(TAG_W-1){1'b0}}};

  // NOTE: non-blocking assignments make the three stages shift together
  // instead of one tag rippling through every stage in a single edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag  <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else if (!hold) begin
      ex_tag  <= bubble ? (id_tag & ~VALID_MASK) : id_tag;
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush
// and memory-busy freeze. Define HAZARD_CTRL_PERF_EN to add event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk_cpu,
  input  logic              rst_cpu,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              rd_we_id,
  input  logic [1:0]        wd_sel_id,
  input  logic              id_valid,
  input  logic              branch_taken_ex,
  input  logic              mem_busy,
  output logic              pc_stop,
  output logic              if_id_stop,
  output logic              id_ex_stop,
  output logic              ex_mem_stop,
  output logic              mem_wb_stop,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [2:0]        rD1_sel,
  output logic [2:0]        rD2_sel
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_freeze_cnt
`endif
);

  localparam int TAG_W = REG_AW + TAG_CTRL_W;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    wd_sel_e           wd_sel;
  } tag_t;

  tag_t id_tag, ex_tag, mem_tag, wb_tag;
  logic freeze, branch_flush, load_use;
  logic hit_ex1, hit_mem1, hit_wb1, hit_ex2, hit_mem2, hit_wb2;

  function automatic logic hit(tag_t t, logic [REG_AW-1:0] rs, logic used);
    return t.valid && t.we && (t.rd == rs) && (rs != '0) && used;
  endfunction

  function automatic fwd_sel_e pick_sel(logic h_ex, logic h_mem, logic h_wb, wd_sel_e ex_wd);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (h_ex) begin
      if (ex_wd == WD_ALU)      sel = FWD_EX_RES;
      else if (ex_wd == WD_IMM) sel = FWD_EX_IMM;
    end else if (h_mem) begin
      sel = FWD_MEM;
    end else if (h_wb) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign id_tag = {id_valid, rd_id, rd_we_id, wd_sel_id};

  hazard_tag_pipe #(
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk     (clk_cpu),
    .rst     (rst_cpu),
    .hold    (freeze),
    .bubble  (id_ex_flush),
    .id_tag  (id_tag),
    .ex_tag  (ex_tag),
    .mem_tag (mem_tag),
    .wb_tag  (wb_tag)
  );

  assign hit_ex1  = hit(ex_tag,  rs1_id, rs1_used_id);
  assign hit_mem1 = hit(mem_tag, rs1_id, rs1_used_id);
  assign hit_wb1  = hit(wb_tag,  rs1_id, rs1_used_id);
  assign hit_ex2  = hit(ex_tag,  rs2_id, rs2_used_id);
  assign hit_mem2 = hit(mem_tag, rs2_id, rs2_used_id);
  assign hit_wb2  = hit(wb_tag,  rs2_id, rs2_used_id);

  assign rD1_sel = pick_sel(hit_ex1, hit_mem1, hit_wb1, ex_tag.wd_sel);
  assign rD2_sel = pick_sel(hit_ex2, hit_mem2, hit_wb2, ex_tag.wd_sel);

  assign freeze       = mem_busy;
  // The EX tag holds across a freeze, so a pending branch is seen again afterwards.
  assign branch_flush = branch_taken_ex && ex_tag.valid;
  assign load_use     = id_valid && (hit_ex1 || hit_ex2) && is_late_result(ex_tag.wd_sel);

  // NOTE: every output gets a default first so no path through the
  // priority chain leaves one unassigned and infers a latch.
  always_comb begin
    pc_stop     = 1'b0;
    if_id_stop  = 1'b0;
    id_ex_stop  = 1'b0;
    ex_mem_stop = 1'b0;
    mem_wb_stop = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (freeze) begin
      pc_stop     = 1'b1;
      if_id_stop  = 1'b1;
      id_ex_stop  = 1'b1;
      ex_mem_stop = 1'b1;
      mem_wb_stop = 1'b1;
    end else if (branch_flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stop     = 1'b1;
      if_id_stop  = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic stall_evt, flush_evt;
  assign stall_evt = load_use && !branch_flush && !freeze;
  assign flush_evt = branch_flush && !freeze;

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_freeze_cnt <= '0;
    end else begin
      if (stall_evt && (perf_stall_cnt != '1))  perf_stall_cnt  <= perf_stall_cnt + PERF_W'(1);
      if (flush_evt && (perf_flush_cnt != '1))  perf_flush_cnt  <= perf_flush_cnt + PERF_W'(1);
      if (freeze && (perf_freeze_cnt != '1))    perf_freeze_cnt <= perf_freeze_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cycle table, reset-mid-stall
// sequence, then random stimulus against a stage-list reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic       clk_cpu = 1'b0;
  logic       rst_cpu = 1'b1;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic       rs1_used_id, rs2_used_id, rd_we_id;
  logic [1:0] wd_sel_id;
  logic       id_valid, branch_taken_ex, mem_busy;
  logic       pc_stop, if_id_stop, id_ex_stop, ex_mem_stop, mem_wb_stop;
  logic       if_id_flush, id_ex_flush;
  logic [2:0] rD1_sel, rD2_sel;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

  hazard_ctrl dut (
    .clk_cpu         (clk_cpu),
    .rst_cpu         (rst_cpu),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rs1_used_id     (rs1_used_id),
    .rs2_used_id     (rs2_used_id),
    .rd_id           (rd_id),
    .rd_we_id        (rd_we_id),
    .wd_sel_id       (wd_sel_id),
    .id_valid        (id_valid),
    .branch_taken_ex (branch_taken_ex),
    .mem_busy        (mem_busy),
    .pc_stop         (pc_stop),
    .if_id_stop      (if_id_stop),
    .id_ex_stop      (id_ex_stop),
    .ex_mem_stop     (ex_mem_stop),
    .mem_wb_stop     (mem_wb_stop),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .rD1_sel         (rD1_sel),
    .rD2_sel         (rD2_sel)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_freeze_cnt (perf_freeze_cnt)
`endif
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we;
    logic [1:0] wd;
    logic       idv, br, busy;
  } vin_t;

  // exp = {pc,if_id,id_ex,ex_mem,mem_wb stops, if_id,id_ex flushes, rD1_sel, rD2_sel}
  typedef struct {
    vin_t        in;
    logic [12:0] exp;
  } vec_t;

  // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit valid;
    int rd;
    bit we;
    int wd;
  } slot_t;

  slot_t       stage_q[3];
  bit          m_lu, m_br, m_fz;
  logic [31:0] m_stall_cnt, m_flush_cnt, m_freeze_cnt;

  int   checks = 0;
  int   errors = 0;
  vec_t tab[17];
  vin_t v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act[12:0], exp[12:0]);
    end
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, pc_stop, if_id_stop, id_ex_stop, ex_mem_stop, mem_wb_stop,
            if_id_flush, id_ex_flush, rD1_sel, rD2_sel};
  endfunction

  function automatic vec_t mk(input int rs1, input int u1, input int rs2, input int u2,
                              input int rd, input int we, input int wd, input int idv,
                              input int br, input int busy, input logic [12:0] exp);
    vec_t r;
    r.in.rs1 = 5'(rs1); r.in.u1 = 1'(u1);
    r.in.rs2 = 5'(rs2); r.in.u2 = 1'(u2);
    r.in.rd  = 5'(rd);  r.in.we = 1'(we); r.in.wd = 2'(wd);
    r.in.idv = 1'(idv); r.in.br = 1'(br); r.in.busy = 1'(busy);
    r.exp = exp;
    return r;
  endfunction

  task automatic drive(input vin_t d);
    rs1_id = d.rs1; rs1_used_id = d.u1;
    rs2_id = d.rs2; rs2_used_id = d.u2;
    rd_id = d.rd; rd_we_id = d.we; wd_sel_id = d.wd;
    id_valid = d.idv; branch_taken_ex = d.br; mem_busy = d.busy;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 3; s++) stage_q[s] = '{valid: 0, rd: 0, we: 0, wd: 0};
    m_stall_cnt = 0; m_flush_cnt = 0; m_freeze_cnt = 0;
  endtask

  // Youngest matching producer wins; EX producers of DRAM/PC4 results cannot forward.
  task automatic model_expect(input vin_t d, output logic [12:0] e);
    int rs[2];
    bit used[2];
    int sel[2];
    bit late;
    late = 0;
    rs[0] = int'(d.rs1); rs[1] = int'(d.rs2);
    used[0] = d.u1; used[1] = d.u2;
    for (int k = 0; k < 2; k++) begin
      sel[k] = 0;
      if (used[k] && rs[k] != 0) begin
        for (int s = 0; s < 3; s++) begin
          if (stage_q[s].valid && stage_q[s].we && stage_q[s].rd == rs[k]) begin
            if (s == 0) begin
              if (stage_q[0].wd == 0)      sel[k] = 1;
              else if (stage_q[0].wd == 2) sel[k] = 2;
              else                         late = 1;
            end else begin
              sel[k] = s + 2;
            end
            break;
          end
        end
      end
    end
    m_fz = d.busy;
    m_br = d.br && stage_q[0].valid && !m_fz;
    m_lu = late && d.idv && !m_br && !m_fz;
    e[12:8] = m_fz ? 5'b11111 : (m_lu ? 5'b11000 : 5'b00000);
    e[7:6]  = m_br ? 2'b11 : (m_lu ? 2'b01 : 2'b00);
    e[5:3]  = 3'(sel[0]);
    e[2:0]  = 3'(sel[1]);
  endtask

  task automatic model_advance(input vin_t d);
    if (!d.busy) begin
      stage_q[2] = stage_q[1];
      stage_q[1] = stage_q[0];
      stage_q[0] = '{valid: d.idv && !(m_br || m_lu), rd: int'(d.rd), we: d.we, wd: int'(d.wd)};
    end
    if (m_lu && m_stall_cnt != '1)  m_stall_cnt++;
    if (m_br && m_flush_cnt != '1)  m_flush_cnt++;
    if (m_fz && m_freeze_cnt != '1) m_freeze_cnt++;
  endtask

  // Entered at posedge+1; returns at the next posedge+1.
  task automatic run_vec(input vin_t d, input bit use_tab, input logic [12:0] tab_exp,
                         input string name);
    logic [12:0] mexp;
    drive(d);
    @(negedge clk_cpu);
    model_expect(d, mexp);
    check(name, outs(), use_tab ? tab_exp : mexp);
    @(posedge clk_cpu);
    model_advance(d);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vin_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'd0).in;
    clear_model();
    drive(idle);
    rst_cpu = 1'b1;
    repeat (2) @(posedge clk_cpu);
    #1;
    // Branch request during reset must not flush: EX holds no valid tag.
    v = idle; v.br = 1'b1; drive(v);
    #1;
    check("reset_state", outs(), 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
    check("perf_reset", perf_stall_cnt | perf_flush_cnt | perf_freeze_cnt, 32'd0);
`endif
    drive(idle);
    @(negedge clk_cpu);
    rst_cpu = 1'b0;
    @(posedge clk_cpu);
    #1;

    //           rs1 u1 rs2 u2 rd we wd idv br busy  {stops, flushes, sel1, sel2}
    tab[0]  = mk(0,  0, 0,  0, 5, 1, 0, 1, 0, 0, {5'b00000, 2'b00, 3'd0, 3'd0});
    tab[1]  = mk(5,  1, 5,  1, 6, 1, 1, 1, 0, 0, {5'b00000, 2'b00, 3'd1, 3'd1});
    tab[2]  = mk(6,  1, 5,  1, 7, 1, 2, 1, 0, 0, {5'b11000, 2'b01, 3'd0, 3'd3});
    tab[3]  = mk(6,  1, 5,  1, 7, 1, 2, 1, 0, 0, {5'b00000, 2'b00, 3'd3, 3'd4});
    tab[4]  = mk(7,  1, 6,  1, 7, 1, 0, 1, 0, 0, {5'b00000, 2'b00, 3'd2, 3'd4});
    tab[5]  = mk(0,  1, 7,  0, 7, 1, 2, 1, 0, 0, {5'b00000, 2'b00, 3'd0, 3'd0});
    tab[6]  = mk(7,  1, 7,  1, 0, 1, 0, 1, 0, 0, {5'b00000, 2'b00, 3'd2, 3'd2});
    tab[7]  = mk(0,  1, 0,  1, 3, 1, 3, 1, 0, 0, {5'b00000, 2'b00, 3'd0, 3'd0});
    tab[8]  = mk(3,  1, 7,  1, 4, 1, 0, 1, 1, 0, {5'b00000, 2'b11, 3'd0, 3'd4});
    tab[9]  = mk(4,  1, 3,  1, 8, 1, 0, 1, 1, 0, {5'b00000, 2'b00, 3'd0, 3'd3});
    tab[10] = mk(8,  1, 3,  1, 9, 1, 0, 1, 1, 1, {5'b11111, 2'b00, 3'd1, 3'd4});
    tab[11] = mk(8,  1, 3,  1, 9, 1, 0, 1, 1, 1, {5'b11111, 2'b00, 3'd1, 3'd4});
    tab[12] = mk(8,  1, 3,  1, 9, 1, 0, 1, 1, 1, {5'b11111, 2'b00, 3'd1, 3'd4});
    tab[13] = mk(8,  1, 3,  1, 9, 1, 0, 1, 1, 0, {5'b00000, 2'b11, 3'd1, 3'd4});
    tab[14] = mk(8,  1, 3,  1, 9, 1, 1, 1, 0, 0, {5'b00000, 2'b00, 3'd3, 3'd0});
    tab[15] = mk(9,  1, 8,  1, 0, 0, 0, 0, 0, 0, {5'b00000, 2'b00, 3'd0, 3'd4});
    tab[16] = mk(0,  0, 0,  0, 10, 1, 1, 1, 0, 0, {5'b00000, 2'b00, 3'd0, 3'd0});

    for (int i = 0; i < 17; i++)
      run_vec(tab[i].in, 1'b1, tab[i].exp, $sformatf("dir%0d", i));

`ifdef HAZARD_CTRL_PERF_EN
    check("perf_stall_dir",  perf_stall_cnt,  32'd1);
    check("perf_flush_dir",  perf_flush_cnt,  32'd2);
    check("perf_freeze_dir", perf_freeze_cnt, 32'd3);
`endif

    // Load x10 sits in EX; ID consumes it, then reset arrives mid-stall.
    v = mk(10, 1, 0, 0, 0, 0, 0, 1, 0, 0, 13'd0).in;
    drive(v);
    @(negedge clk_cpu);
    check("stall_before_rst", outs(), {19'd0, 5'b11000, 2'b01, 3'd0, 3'd0});
    #1 rst_cpu = 1'b1;
    #1 check("rst_mid_stall", outs(), 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
    check("perf_rst_mid_stall", perf_stall_cnt | perf_flush_cnt | perf_freeze_cnt, 32'd0);
`endif
    clear_model();
    drive(idle);
    @(posedge clk_cpu);
    #1 rst_cpu = 1'b0;

    for (int n = 0; n < 400; n++) begin
      v.rs1  = 5'($urandom_range(0, 7));
      v.rs2  = 5'($urandom_range(0, 7));
      v.u1   = 1'($urandom_range(0, 3) != 0);
      v.u2   = 1'($urandom_range(0, 3) != 0);
      v.rd   = 5'($urandom_range(0, 7));
      v.we   = 1'($urandom_range(0, 4) != 0);
      v.wd   = 2'($urandom_range(0, 3));
      v.idv  = 1'($urandom_range(0, 4) != 0);
      v.br   = 1'($urandom_range(0, 5) == 0);
      v.busy = 1'($urandom_range(0, 6) == 0);
      run_vec(v, 1'b0, 13'd0, $sformatf("rand%0d", n));
    end

`ifdef HAZARD_CTRL_PERF_EN
    check("perf_stall_rand",  perf_stall_cnt,  m_stall_cnt);
    check("perf_flush_rand",  perf_flush_cnt,  m_flush_cnt);
    check("perf_freeze_rand", perf_freeze_cnt, m_freeze_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
